grid_piece_mover: RTL

//  Parametrised move engine for the active Tetris piece. Takes one move command (down/left/right/hard-drop),

---
 rtl/tetris_pkg.sv | 39 +++
 rtl/grid_cell_addr.sv | 15 +
 rtl/grid_piece_mover.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared codes for the Tetris grid engines: block colours, move directions,
// move results and the piece-mover state encoding.
package tetris_pkg;

  localparam logic [3:0] BLOCK_AIR = 4'd0;
  localparam logic [3:0] BLOCK_I   = 4'd1;
  localparam logic [3:0] BLOCK_O   = 4'd2;
  localparam logic [3:0] BLOCK_T   = 4'd3;
  localparam logic [3:0] BLOCK_S   = 4'd4;
  localparam logic [3:0] BLOCK_Z   = 4'd5;
  localparam logic [3:0] BLOCK_J   = 4'd6;
  localparam logic [3:0] BLOCK_L   = 4'd7;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DROP  = 2'b11;

  localparam logic [1:0] RES_MOVED   = 2'b00;
  localparam logic [1:0] RES_BLOCKED = 2'b01;
  localparam logic [1:0] RES_LANDED  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK_A = 3'd1,
    ST_CHK_D = 3'd2,
    ST_COL_A = 3'd3,
    ST_COL_D = 3'd4,
    ST_ERASE = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } mover_state_e;

  // Down and hard drop both move vertically; a blocked vertical move means the piece landed.
  function automatic logic dir_is_vertical(input logic [1:0] dir);
    return (dir == DIR_DOWN) || (dir == DIR_DROP);
  endfunction

endpackage

// File: rtl/grid_cell_addr.sv
// Grid (row, col) to linear RAM address: row*GRID_COLS + col.
module grid_cell_addr #(
  parameter int unsigned GRID_COLS = 12,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned COL_W     = 4,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_W-1:0]  i_col,
  output logic [ADDR_W-1:0] o_addr
);

  assign o_addr = ADDR_W'(i_row) * ADDR_W'(GRID_COLS) + ADDR_W'(i_col);

endmodule

// File: rtl/grid_piece_mover.sv
// Move engine for the active piece: collision-checks a move against grid RAM,
// then erases the old cells and writes the new ones, reporting a result code.
module grid_piece_mover
  import tetris_pkg::*;
#(
  parameter int unsigned GRID_COLS = 12,
  parameter int unsigned GRID_ROWS = 20,
  parameter int unsigned CELLS     = 4,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned COL_W     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CELL_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [CELLS*ROW_W-1:0] load_row,
  input  logic [CELLS*COL_W-1:0] load_col,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_dir,
  output logic                   done,
  output logic [1:0]             result,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [CELL_W-1:0]      mem_wdata,
  output logic                   mem_we,
  input  logic [CELL_W-1:0]      mem_rdata,
  output logic [CELLS*ROW_W-1:0] piece_row,
  output logic [CELLS*COL_W-1:0] piece_col
);

  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

  mover_state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt;
  logic [1:0]               r_dir, w_dir_nxt;
  logic                     r_blocked, w_blocked_nxt;
  logic [CELL_W-1:0]        r_colour, w_colour_nxt;
  logic [CELLS*ROW_W-1:0]   r_row, w_row_nxt;
  logic [CELLS*COL_W-1:0]   r_col, w_col_nxt;
  logic                     r_done;
  logic [1:0]               r_result, w_result_nxt;
  logic [ADDR_W-1:0]        r_mem_addr, w_mem_addr_nxt;
  logic [CELL_W-1:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic                     r_mem_we, w_mem_we_nxt;

  logic [ROW_W-1:0]         w_cur_row, w_src_row, w_tgt_row, w_addr_row;
  logic [COL_W-1:0]         w_cur_col, w_src_col, w_tgt_col, w_addr_col;
  logic                     w_cur_ok, w_self_hit, w_hit, w_blk_now, w_tgt_ok;
  logic [ADDR_W-1:0]        w_addr;

  function automatic logic [ROW_W-1:0] tgt_row(input logic [ROW_W-1:0] row, input logic [1:0] dir);
    return dir_is_vertical(dir) ? row + ROW_W'(1) : row;
  endfunction

  function automatic logic [COL_W-1:0] tgt_col(input logic [COL_W-1:0] col, input logic [1:0] dir);
    logic [COL_W-1:0] c;
    c = col;
    if (dir == DIR_LEFT)  c = col - COL_W'(1);
    if (dir == DIR_RIGHT) c = col + COL_W'(1);
    return c;
  endfunction

  // Wall columns and the row below the floor are never legal targets.
  function automatic logic cell_ok(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return (col != '0) && (col != COL_W'(GRID_COLS - 1)) && (row < ROW_W'(GRID_ROWS));
  endfunction

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_dir_nxt     = r_dir;
    w_blocked_nxt = r_blocked;
    w_colour_nxt  = r_colour;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_result_nxt  = r_result;

    w_cur_row  = tgt_row(r_row[r_idx*ROW_W +: ROW_W], r_dir);
    w_cur_col  = tgt_col(r_col[r_idx*COL_W +: COL_W], r_dir);
    w_cur_ok   = cell_ok(w_cur_row, w_cur_col);
    w_self_hit = 1'b0;
    for (int j = 0; j < CELLS; j++) begin
      if (r_row[j*ROW_W +: ROW_W] == w_cur_row && r_col[j*COL_W +: COL_W] == w_cur_col)
        w_self_hit = 1'b1;
    end
    w_hit     = !w_cur_ok || ((mem_rdata[3:0] != BLOCK_AIR) && !w_self_hit);
    w_blk_now = r_blocked || w_hit;

    unique case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_row_nxt = load_row;
          w_col_nxt = load_col;
        end else if (cmd_valid) begin
          w_dir_nxt     = cmd_dir;
          w_idx_nxt     = '0;
          w_blocked_nxt = 1'b0;
          w_state_nxt   = ST_CHK_A;
        end
      end
      ST_CHK_A: w_state_nxt = ST_CHK_D;
      ST_CHK_D: begin
        w_blocked_nxt = w_blk_now;
        if (r_idx != IDX_LAST) begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = ST_CHK_A;
        end else if (w_blk_now) begin
          w_result_nxt = dir_is_vertical(r_dir) ? RES_LANDED : RES_BLOCKED;
          w_state_nxt  = ST_DONE;
        end else begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_COL_A;
        end
      end
      ST_COL_A: w_state_nxt = ST_COL_D;
      ST_COL_D: begin
        w_colour_nxt = mem_rdata;
        w_idx_nxt    = '0;
        w_state_nxt  = ST_ERASE;
      end
      ST_ERASE: begin
        w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        if (r_idx == IDX_LAST) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (r_idx != IDX_LAST) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end else begin
          for (int j = 0; j < CELLS; j++) begin
            w_row_nxt[j*ROW_W +: ROW_W] = tgt_row(r_row[j*ROW_W +: ROW_W], r_dir);
            w_col_nxt[j*COL_W +: COL_W] = tgt_col(r_col[j*COL_W +: COL_W], r_dir);
          end
          w_idx_nxt = '0;
          // Hard drop keeps stepping down until a check pass blocks.
          if (r_dir == DIR_DROP) begin
            w_blocked_nxt = 1'b0;
            w_state_nxt   = ST_CHK_A;
          end else begin
            w_result_nxt = RES_MOVED;
            w_state_nxt  = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Cell feeding the shared address calculator, chosen from next-cycle state so mem_addr is registered.
  always_comb begin
    w_src_row = w_row_nxt[w_idx_nxt*ROW_W +: ROW_W];
    w_src_col = w_col_nxt[w_idx_nxt*COL_W +: COL_W];
    w_tgt_row = tgt_row(w_src_row, w_dir_nxt);
    w_tgt_col = tgt_col(w_src_col, w_dir_nxt);
    w_tgt_ok  = cell_ok(w_tgt_row, w_tgt_col);
    if (w_state_nxt == ST_ERASE || w_state_nxt == ST_COL_A) begin
      w_addr_row = w_src_row;
      w_addr_col = w_src_col;
    end else begin
      w_addr_row = w_tgt_row;
      w_addr_col = w_tgt_col;
    end
  end

  grid_cell_addr #(
    .GRID_COLS (GRID_COLS),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .ADDR_W    (ADDR_W)
  ) u_addr (
    .i_row  (w_addr_row),
    .i_col  (w_addr_col),
    .o_addr (w_addr)
  );

  // RAM port drive; illegal targets leave the address untouched so walls and the floor are never read.
  always_comb begin
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_we_nxt    = 1'b0;
    w_mem_wdata_nxt = '0;
    unique case (w_state_nxt)
      ST_CHK_A: if (w_tgt_ok) w_mem_addr_nxt = w_addr;
      ST_COL_A: w_mem_addr_nxt = w_addr;
      ST_ERASE: begin
        w_mem_addr_nxt = w_addr;
        w_mem_we_nxt   = 1'b1;
      end
      ST_WRITE: begin
        w_mem_addr_nxt  = w_addr;
        w_mem_we_nxt    = 1'b1;
        w_mem_wdata_nxt = w_colour_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_dir       <= DIR_DOWN;
      r_blocked   <= 1'b0;
      r_colour    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_done      <= 1'b0;
      r_result    <= RES_MOVED;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dir       <= w_dir_nxt;
      r_blocked   <= w_blocked_nxt;
      r_colour    <= w_colour_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
      r_result    <= w_result_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
    end
  end

  // Load wins over a same-cycle command, so cmd_ready drops while load_valid is high.
  assign load_ready = (r_state == ST_IDLE);
  assign cmd_ready  = (r_state == ST_IDLE) && !load_valid;
  assign done       = r_done;
  assign result     = r_result;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign piece_row  = r_row;
  assign piece_col  = r_col;

endmodule
